// File: rtl/edac_scrubber_if.sv
// Scrubber-side view of the EDAC RAM port: scrub control, bus handshake/strobes,
// corrected read data with decoder error flags, and status outputs.
interface edac_scrubber_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 8
);
  logic                   SCRUB_EN;
  logic                   TICK;
  logic                   SCRUB_REQ;
  logic                   SCRUB_GNT;
  logic [ADDR_WIDTH-1:0]  SCRUB_ADDR;
  logic                   SCRUB_nRD;
  logic                   SCRUB_nWR;
  logic [DATA_WIDTH-1:0]  RDATA;
  logic [DATA_WIDTH-1:0]  WDATA;
  logic                   ERR_DET_C;
  logic                   ERR_UNCORR;
  logic [COUNT_WIDTH-1:0] FIX_COUNT;
  logic                   UNCORR_SEEN;
  logic                   PASS_DONE;
  logic                   SCRUB_BUSY;

  modport master (
    input  SCRUB_EN, TICK, SCRUB_GNT, RDATA, ERR_DET_C, ERR_UNCORR,
    output SCRUB_REQ, SCRUB_ADDR, SCRUB_nRD, SCRUB_nWR, WDATA,
           FIX_COUNT, UNCORR_SEEN, PASS_DONE, SCRUB_BUSY
  );

  modport slave (
    output SCRUB_EN, TICK, SCRUB_GNT, RDATA, ERR_DET_C, ERR_UNCORR,
    input  SCRUB_REQ, SCRUB_ADDR, SCRUB_nRD, SCRUB_nWR, WDATA,
           FIX_COUNT, UNCORR_SEEN, PASS_DONE, SCRUB_BUSY
  );
endinterface

// File: rtl/edac_scrubber.sv
// EDAC memory scrubber: walks the RAM one address per TICK, reads through the decoder
// and rewrites corrected data. Define SCRUB_WRITEBACK_EN to enable write-back;
// without it the scrubber only counts correctable errors.
module edac_scrubber #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int COUNT_WIDTH   = 8,
  parameter int STROBE_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              nRESET,
  edac_scrubber_if.master   bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] REQ     = 3'd1;
  localparam logic [2:0] READ    = 3'd2;
  localparam logic [2:0] CHECK   = 3'd3;
  localparam logic [2:0] WRITE   = 3'd4;
  localparam logic [2:0] RELEASE = 3'd5;

  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

  logic [2:0]             state;
  logic                   pending;
  logic [3:0]             strobe_cnt;
  logic [ADDR_WIDTH-1:0]  addr;
  logic                   det_q;
  logic                   uncorr_q;
  logic [COUNT_WIDTH-1:0] fix_count;
  logic                   uncorr_seen;
`ifdef SCRUB_WRITEBACK_EN
  logic [DATA_WIDTH-1:0]  data_q;
`endif

  // Losing the grant mid-strobe drops back to IDLE with the step re-armed, so the
  // same address is retried once the mux hands the bus back.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state       <= IDLE;
      pending     <= 1'b0;
      strobe_cnt  <= 4'd0;
      addr        <= '0;
      det_q       <= 1'b0;
      uncorr_q    <= 1'b0;
      fix_count   <= '0;
      uncorr_seen <= 1'b0;
`ifdef SCRUB_WRITEBACK_EN
      data_q      <= '0;
`endif
    end else begin
      if (bus.TICK && bus.SCRUB_EN) begin
        pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (pending && bus.SCRUB_EN) begin
            state   <= REQ;
            pending <= 1'b0;
          end
        end
        REQ: begin
          if (bus.SCRUB_GNT) begin
            state      <= READ;
            strobe_cnt <= 4'd0;
          end
        end
        READ: begin
          if (!bus.SCRUB_GNT) begin
            state   <= IDLE;
            pending <= 1'b1;
          end else if (strobe_cnt == STROBE_LAST) begin
            det_q    <= bus.ERR_DET_C;
            uncorr_q <= bus.ERR_UNCORR;
`ifdef SCRUB_WRITEBACK_EN
            data_q   <= bus.RDATA;
`endif
            state    <= CHECK;
          end else begin
            strobe_cnt <= strobe_cnt + 4'd1;
          end
        end
        CHECK: begin
          strobe_cnt <= 4'd0;
          if (uncorr_q) begin
            uncorr_seen <= 1'b1;
            state       <= RELEASE;
          end else if (det_q) begin
`ifdef SCRUB_WRITEBACK_EN
            state <= WRITE;
`else
            if (fix_count != '1) begin
              fix_count <= fix_count + 1'b1;
            end
            state <= RELEASE;
`endif
          end else begin
            state <= RELEASE;
          end
        end
        WRITE: begin
          if (!bus.SCRUB_GNT) begin
            state   <= IDLE;
            pending <= 1'b1;
          end else if (strobe_cnt == STROBE_LAST) begin
            if (fix_count != '1) begin
              fix_count <= fix_count + 1'b1;
            end
            state <= RELEASE;
          end else begin
            strobe_cnt <= strobe_cnt + 4'd1;
          end
        end
        RELEASE: begin
          addr  <= addr + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from registered state so reset releases strobes at once.
  assign bus.SCRUB_REQ   = (state != IDLE);
  assign bus.SCRUB_BUSY  = (state != IDLE);
  assign bus.SCRUB_nRD   = (state != READ);
  assign bus.SCRUB_ADDR  = addr;
  assign bus.FIX_COUNT   = fix_count;
  assign bus.UNCORR_SEEN = uncorr_seen;
  assign bus.PASS_DONE   = (state == RELEASE) && (addr == '1);
`ifdef SCRUB_WRITEBACK_EN
  assign bus.SCRUB_nWR   = (state != WRITE);
  assign bus.WDATA       = data_q;
`else
  assign bus.SCRUB_nWR   = 1'b1;
  assign bus.WDATA       = '0;
`endif

endmodule

// File: tb/tb_edac_scrubber.sv
// Self-checking bench for edac_scrubber (4-bit address so a full pass is short);
// works with or without SCRUB_WRITEBACK_EN defined.
module tb_edac_scrubber;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int CW = 8;
  localparam int SC = 2;
`ifdef SCRUB_WRITEBACK_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif

  logic CLK = 1'b0;
  logic nRESET;

  edac_scrubber_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

  edac_scrubber #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COUNT_WIDTH(CW), .STROBE_CYCLES(SC)
  ) dut (
    .CLK(CLK),
    .nRESET(nRESET),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  logic [AW-1:0] m_addr = '0;
  logic [CW-1:0] m_fix = '0;
  logic          m_uncorr = 1'b0;
  bit            model_ok = 1'b0;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Whenever the scrubber is idle its visible state must match the model.
  always @(negedge CLK) begin
    if (nRESET) begin
      check_output("strobe_overlap", 32'(!bus.SCRUB_nRD && !bus.SCRUB_nWR), 32'd0);
      if (model_ok && !bus.SCRUB_BUSY) begin
        check_output("idle_addr", 32'(bus.SCRUB_ADDR), 32'(m_addr));
        check_output("idle_fix_count", 32'(bus.FIX_COUNT), 32'(m_fix));
        check_output("idle_uncorr_seen", 32'(bus.UNCORR_SEEN), 32'(m_uncorr));
        check_output("idle_strobes", {30'd0, bus.SCRUB_nRD, bus.SCRUB_nWR}, 32'd3);
        check_output("idle_req", 32'(bus.SCRUB_REQ), 32'd0);
        check_output("idle_pass_done", 32'(bus.PASS_DONE), 32'd0);
      end
    end
  end

  // One scrub step. abort_phase: 0 none, 1 drop grant in read, 2 drop grant in write.
  task automatic apply_stimulus(input logic [DW-1:0] rdata, input bit det, input bit uncorr,
                                input int abort_phase, input int gnt_delay, input bit en_drop);
    logic [AW-1:0] start_addr;
    logic [AW-1:0] abort_addr;
    logic          abort_busy;
    int rd_runs[$];
    int wr_runs[$];
    int exp_rd[$];
    int exp_wr[$];
    int cur_rd, cur_wr, pass_cycles, idle_run, gnt_off, cycles, req_seen;
    bit seen_busy, aborted, abort_sampled, done, wdata_ok, granted, writes;
    start_addr = m_addr;
    abort_addr = '0;
    abort_busy = 1'b1;
    cur_rd = 0; cur_wr = 0; pass_cycles = 0; idle_run = 0; gnt_off = 0; cycles = 0;
    req_seen = 0;
    seen_busy = 0; aborted = 0; abort_sampled = 0; done = 0; wdata_ok = 1;
    granted = (gnt_delay == 0);
    model_ok = 1'b0;
    @(negedge CLK);
    bus.RDATA = rdata;
    bus.ERR_DET_C = det;
    bus.ERR_UNCORR = uncorr;
    bus.SCRUB_EN = 1'b1;
    bus.SCRUB_GNT = granted;
    bus.TICK = 1'b1;
    @(negedge CLK);
    bus.TICK = 1'b0;
    while (cycles < 200) begin
      cycles++;
      if (!bus.SCRUB_nRD) cur_rd++;
      else if (cur_rd > 0) begin rd_runs.push_back(cur_rd); cur_rd = 0; end
      if (!bus.SCRUB_nWR) cur_wr++;
      else if (cur_wr > 0) begin wr_runs.push_back(cur_wr); cur_wr = 0; end
      if (WB && !bus.SCRUB_nWR && bus.WDATA !== rdata) wdata_ok = 0;
      if (!WB && bus.WDATA !== '0) wdata_ok = 0;
      if (bus.PASS_DONE) pass_cycles++;
      if (aborted && !abort_sampled) begin
        abort_addr = bus.SCRUB_ADDR;
        abort_busy = bus.SCRUB_BUSY;
        abort_sampled = 1;
      end
      if (bus.SCRUB_BUSY) begin seen_busy = 1; idle_run = 0; end
      else if (seen_busy) idle_run++;
      if (idle_run >= 2) begin done = 1; break; end
      if (en_drop && seen_busy) bus.SCRUB_EN = 1'b0;
      if (!granted && bus.SCRUB_REQ) begin
        req_seen++;
        if (req_seen >= gnt_delay) begin bus.SCRUB_GNT = 1'b1; granted = 1; end
      end
      if (gnt_off > 0) begin
        gnt_off--;
        if (gnt_off == 0) bus.SCRUB_GNT = 1'b1;
      end
      if (!aborted && ((abort_phase == 1 && !bus.SCRUB_nRD) ||
                       (abort_phase == 2 && !bus.SCRUB_nWR))) begin
        bus.SCRUB_GNT = 1'b0;
        aborted = 1;
        gnt_off = 3;
      end
      @(negedge CLK);
    end
    check_output("step_done", 32'(done), 32'd1);

    writes = WB && det && !uncorr;
    if (abort_phase == 1) exp_rd.push_back(1);
    if (abort_phase == 2) exp_rd.push_back(SC);
    exp_rd.push_back(SC);
    if (writes) begin
      if (abort_phase == 2) exp_wr.push_back(1);
      exp_wr.push_back(SC);
    end
    check_output("rd_strobe_count", 32'(rd_runs.size()), 32'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size() && i < rd_runs.size(); i++)
      check_output("rd_strobe_len", 32'(rd_runs[i]), 32'(exp_rd[i]));
    check_output("wr_strobe_count", 32'(wr_runs.size()), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < wr_runs.size(); i++)
      check_output("wr_strobe_len", 32'(wr_runs[i]), 32'(exp_wr[i]));
    check_output("wdata", 32'(wdata_ok), 32'd1);
    check_output("pass_done_cycles", 32'(pass_cycles), (start_addr == '1) ? 32'd1 : 32'd0);
    if (abort_phase != 0) begin
      check_output("abort_seen", 32'(abort_sampled), 32'd1);
      check_output("abort_addr_held", 32'(abort_addr), 32'(start_addr));
      check_output("abort_to_idle", 32'(abort_busy), 32'd0);
    end

    m_addr = start_addr + 1'b1;
    if (uncorr) m_uncorr = 1'b1;
    else if (det && m_fix != '1) m_fix = m_fix + 1'b1;
    bus.SCRUB_EN = 1'b1;
    model_ok = 1'b1;
  endtask

  task automatic apply_reset();
    model_ok = 1'b0;
    nRESET = 1'b0;
    #1;
    check_output("rst_addr", 32'(bus.SCRUB_ADDR), 32'd0);
    check_output("rst_fix_count", 32'(bus.FIX_COUNT), 32'd0);
    check_output("rst_uncorr_seen", 32'(bus.UNCORR_SEEN), 32'd0);
    check_output("rst_nrd", 32'(bus.SCRUB_nRD), 32'd1);
    check_output("rst_nwr", 32'(bus.SCRUB_nWR), 32'd1);
    check_output("rst_req", 32'(bus.SCRUB_REQ), 32'd0);
    check_output("rst_busy", 32'(bus.SCRUB_BUSY), 32'd0);
    check_output("rst_pass_done", 32'(bus.PASS_DONE), 32'd0);
    check_output("rst_wdata", 32'(bus.WDATA), 32'd0);
    repeat (2) @(negedge CLK);
    nRESET = 1'b1;
    m_addr = '0;
    m_fix = '0;
    m_uncorr = 1'b0;
    model_ok = 1'b1;
  endtask

  initial begin
    int wait_cycles;
    bus.SCRUB_EN = 1'b0;
    bus.TICK = 1'b0;
    bus.SCRUB_GNT = 1'b0;
    bus.RDATA = '0;
    bus.ERR_DET_C = 1'b0;
    bus.ERR_UNCORR = 1'b0;
    nRESET = 1'b1;
    @(negedge CLK);
    apply_reset();

    apply_stimulus(8'h00, 0, 0, 0, 0, 0);
    check_output("first_step_addr", 32'(bus.SCRUB_ADDR), 32'd1);
    check_output("first_step_fix", 32'(bus.FIX_COUNT), 32'd0);

    for (int i = 1; i < 5; i++) apply_stimulus(8'h11, 0, 0, 0, 0, 0);
    apply_stimulus(8'hA5, 1, 0, 0, 0, 0);
    check_output("fix_at_5_addr", 32'(bus.SCRUB_ADDR), 32'd6);
    check_output("fix_at_5_count", 32'(bus.FIX_COUNT), 32'd1);

    apply_stimulus(8'h5A, 1, 1, 0, 0, 0);
    check_output("uncorr_seen_set", 32'(bus.UNCORR_SEEN), 32'd1);
    check_output("uncorr_fix_held", 32'(bus.FIX_COUNT), 32'd1);
    apply_stimulus(8'h00, 0, 0, 0, 0, 0);
    check_output("uncorr_seen_sticky", 32'(bus.UNCORR_SEEN), 32'd1);

    apply_stimulus(8'h42, 0, 0, 1, 0, 0);
    check_output("read_abort_retry_addr", 32'(bus.SCRUB_ADDR), 32'd9);
    if (WB) apply_stimulus(8'h3C, 1, 0, 2, 0, 0);
    else    apply_stimulus(8'h3C, 1, 0, 0, 0, 0);
    check_output("fix_after_addr9", 32'(bus.FIX_COUNT), 32'd2);
    apply_stimulus(8'h00, 0, 0, 0, 3, 0);
    apply_stimulus(8'h77, 1, 0, 0, 0, 1);

    // A TICK with scrubbing disabled must not arm a step.
    @(negedge CLK);
    bus.SCRUB_EN = 1'b0;
    bus.TICK = 1'b1;
    @(negedge CLK);
    bus.TICK = 1'b0;
    repeat (2) @(negedge CLK);
    check_output("no_start_en_off", 32'(bus.SCRUB_BUSY), 32'd0);
    bus.SCRUB_EN = 1'b1;
    repeat (3) @(negedge CLK);
    check_output("no_late_start", 32'(bus.SCRUB_BUSY), 32'd0);

    // Reset during a read strobe.
    model_ok = 1'b0;
    bus.ERR_DET_C = 1'b1;
    bus.ERR_UNCORR = 1'b0;
    bus.SCRUB_GNT = 1'b1;
    bus.TICK = 1'b1;
    @(negedge CLK);
    bus.TICK = 1'b0;
    wait_cycles = 0;
    while (bus.SCRUB_nRD && wait_cycles < 20) begin
      @(negedge CLK);
      wait_cycles++;
    end
    check_output("rd_before_reset", 32'(bus.SCRUB_nRD), 32'd0);
    #2;
    apply_reset();

    for (int i = 0; i < 16; i++) apply_stimulus(8'h00, 0, 0, 0, 0, 0);
    check_output("pass_wrap_addr", 32'(bus.SCRUB_ADDR), 32'd0);

    for (int i = 0; i < 255; i++) apply_stimulus(8'(i), 1, 0, 0, 0, 0);
    check_output("fix_reaches_ff", 32'(bus.FIX_COUNT), 32'hFF);
    apply_stimulus(8'hC3, 1, 0, 0, 0, 0);
    check_output("fix_saturates", 32'(bus.FIX_COUNT), 32'hFF);

    repeat (3) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/edac_scrubber.md
EDAC_SCRUBBER -- requirements
Module: edac_scrubber

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, EDAC RAM address bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, RAM data bits (corrected, post-decoder).
REQ-003 SHALL have parameter COUNT_WIDTH, default 8, fix-counter bits.
REQ-004 SHALL have parameter STROBE_CYCLES, default 2, strobe low time in CLK cycles, legal range 1..15.
REQ-005 SHALL have ports: CLK in 1 system clock; nRESET in 1 asynchronous active-low reset.
REQ-006 SHALL have ports: SCRUB_EN in 1 scrubbing enable; TICK in 1 one-cycle scrub-step request.
REQ-007 SHALL have ports: SCRUB_REQ out 1 bus request; SCRUB_GNT in 1 bus grant from access mux.
REQ-008 SHALL have ports: SCRUB_ADDR out ADDR_WIDTH current address; SCRUB_nRD out 1; SCRUB_nWR out 1.
REQ-009 SHALL have ports: RDATA in DATA_WIDTH corrected read data; WDATA out DATA_WIDTH write-back data.
REQ-010 SHALL have ports: ERR_DET_C in 1 combinational correctable-error detect; ERR_UNCORR in 1 combinational double-error detect.
REQ-011 SHALL have ports: FIX_COUNT out COUNT_WIDTH; UNCORR_SEEN out 1 sticky; PASS_DONE out 1 pulse; SCRUB_BUSY out 1.

Function
REQ-012 SHALL use one CLK domain, all state on posedge CLK; FSM states IDLE, REQ, READ, CHECK, WRITE, RELEASE.
REQ-013 SHALL set a one-bit pending flag on TICK=1 while SCRUB_EN=1; further TICKs while pending or non-IDLE merge (no queueing).
REQ-014 IDLE -> REQ when pending=1 and SCRUB_EN=1; pending clears on that transition; SCRUB_REQ=1 in REQ..RELEASE inclusive.
REQ-015 REQ -> READ on first edge with SCRUB_GNT=1; REQ waits indefinitely otherwise.
REQ-016 READ: SCRUB_nRD=0 for exactly STROBE_CYCLES cycles; RDATA, ERR_DET_C, ERR_UNCORR captured on the edge ending READ.
REQ-017 CHECK (one cycle): captured ERR_UNCORR=1 -> set UNCORR_SEEN, no write, go RELEASE.
REQ-018 CHECK: ERR_DET_C=1 and ERR_UNCORR=0 -> WRITE; otherwise -> RELEASE.
REQ-019 WRITE: WDATA = captured RDATA, stable whole state; SCRUB_nWR=0 for exactly STROBE_CYCLES cycles; FIX_COUNT increments by 1 on exit.
REQ-020 FIX_COUNT SHALL saturate at all-ones; no wrap.
REQ-021 RELEASE (one cycle): SCRUB_ADDR increments; at all-ones wraps to 0 and PASS_DONE=1 for that one cycle; then IDLE.
REQ-022 SCRUB_nRD and SCRUB_nWR SHALL never be low together, and each SHALL be high for at least one cycle between strobes.
REQ-023 SCRUB_GNT=0 in READ or WRITE SHALL abort: strobes high next cycle, go IDLE, address not advanced, pending set again (step retried), FIX_COUNT unchanged.
REQ-024 SCRUB_EN=0 mid-operation SHALL NOT abort; current step completes; no new step starts while SCRUB_EN=0.
REQ-025 SCRUB_BUSY=1 in every state except IDLE.
REQ-026 UNCORR_SEEN SHALL clear only on reset.

Reset
REQ-027 nRESET=0 SHALL asynchronously force: state IDLE, pending 0, SCRUB_REQ 0, SCRUB_nRD 1, SCRUB_nWR 1, SCRUB_ADDR 0, WDATA 0, FIX_COUNT 0, UNCORR_SEEN 0, PASS_DONE 0, SCRUB_BUSY 0.
REQ-028 Reset mid-strobe SHALL release strobes immediately (asynchronously), with no write completion counted.

Configuration
REQ-029 Macro SCRUB_WRITEBACK_EN defined: behaviour as above.
REQ-030 Macro SCRUB_WRITEBACK_EN undefined: WRITE never entered; SCRUB_nWR constant 1; WDATA constant 0; FIX_COUNT counts detected correctable errors on CHECK exit (detect-and-count only).

Verification
REQ-031 Reset; SCRUB_EN=1, TICK pulse, GNT=1 immediately, no errors -> one nRD strobe 2 cycles long, no nWR, SCRUB_ADDR 0->1, FIX_COUNT 0.
REQ-032 Step at addr 0x0005 with ERR_DET_C=1, RDATA=0xA5 -> nWR low 2 cycles with WDATA=0xA5, FIX_COUNT=1, addr 0x0006.
REQ-033 ERR_UNCORR=1 at read -> no nWR, UNCORR_SEEN=1 and stays 1, FIX_COUNT unchanged.
REQ-034 GNT dropped mid-READ -> nRD high next cycle, addr unchanged, after GNT returns same address re-read once.
REQ-035 ADDR_WIDTH=4, 16 clean steps from 0 -> PASS_DONE single pulse on 16th RELEASE, addr=0; FIX_COUNT preset to 0xFF via 255 fixes plus one more -> stays 0xFF.
REQ-036 Build without SCRUB_WRITEBACK_EN, ERR_DET_C=1 step -> nWR stays 1, FIX_COUNT=1.
